vid_dma_fetch: RTL and testbench
================================

VID_DMA_FETCH -- requirements
Module: vid_dma_fetch

Interface
REQ-001 Parameter FIFO_AW, default 4, FIFO address width; FIFO depth is 2^FIFO_AW words of 32 bits; legal range 3..8.
REQ-002 wb_clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 wb_rst_n  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  single-cycle pulse that launches a transfer.
REQ-005 base_adr  in  22  word-aligned start address, byte address bits [23:2]; bits [3:2] are ignored, so transfers start on a 16-byte boundary.
REQ-006 len  in  16  transfer length in 4-word bursts; 0 is treated as 1.
REQ-007 wb_adr  out  24  wishbone byte address; bits [1:0] are always 0.
REQ-008 wb_cti  out  3  3'b010 on burst beats 0-2, 3'b111 on beat 3.
REQ-009 wb_stb, wb_cyc  out  1 each  bus request; always equal to each other.
REQ-010 wb_we  out  1  constant 0; wb_sel  out  4  constant 4'hF.
REQ-011 wb_dat_i  in  32  read data; wb_ack  in  1  per-beat acknowledge.
REQ-012 rd_en  in  1  consumer pop; rd_data  out  32  FIFO head word (show-ahead).
REQ-013 empty  out  1; level  out  FIFO_AW+1  current FIFO occupancy.
REQ-014 busy  out  1  transfer in progress; done  out  1  single-cycle completion pulse.

Function
REQ-015 The FSM SHALL have the states IDLE, WAIT, BURST and FINISH.
REQ-016 In IDLE, start SHALL latch base_adr (with [3:2] forced to 0) into cur_adr, latch the burst count into remaining, clear the FIFO, set busy and go to WAIT; start in any other state SHALL be ignored.
REQ-017 WAIT SHALL move to BURST when free space (2^FIFO_AW minus level) is at least 4; otherwise it SHALL stay in WAIT with wb_cyc low.
REQ-018 In BURST, wb_cyc and wb_stb SHALL be registered high, wb_adr SHALL equal cur_adr, and wb_cti SHALL follow REQ-008 according to the beat counter.
REQ-019 Each wb_ack in BURST SHALL write wb_dat_i into the FIFO, add 4 to cur_adr and increment the 2-bit beat counter.
REQ-020 wb_cyc and wb_stb SHALL be low in the cycle after the beat-3 ack, with no extra stall beat, on every burst.
REQ-021 After the beat-3 ack, remaining SHALL decrement; the FSM SHALL go to FINISH if remaining becomes 0, otherwise to WAIT.
REQ-022 FINISH SHALL pulse done for one cycle, clear busy and return to IDLE.
REQ-023 A pop when not empty SHALL advance the read pointer; a pop when empty SHALL be ignored and leave level unchanged.
REQ-024 A simultaneous push and pop SHALL leave level unchanged.
REQ-025 FIFO pointers SHALL wrap modulo 2^FIFO_AW.
REQ-026 cur_adr SHALL wrap modulo 2^24 without error.
REQ-027 rd_data SHALL be valid in the same cycle that empty is low.
REQ-028 Pushes into a full FIFO SHALL never occur; REQ-017 guarantees this.
REQ-029 wb_ack received outside BURST SHALL be ignored.

Reset
REQ-030 While wb_rst_n is low: FSM in IDLE; wb_cyc, wb_stb, busy, done = 0; wb_cti = 3'b000; wb_adr = 0; FIFO pointers = 0; level = 0; empty = 1.
REQ-031 Reset asserted mid-burst SHALL drop wb_cyc immediately and abandon the transfer; no done pulse SHALL be produced.
REQ-032 Reset release SHALL be synchronised internally so that the FSM leaves IDLE no earlier than the second wb_clk edge after deassertion.

Configuration
REQ-033 With DMA_LOOP_EN defined, reaching remaining = 0 SHALL pulse done, reload cur_adr and remaining from the latched values, and go to WAIT, keeping busy high; the transfer then stops only on reset.
REQ-034 Without DMA_LOOP_EN, the end of a transfer SHALL behave per REQ-021 and REQ-022.

Verification
REQ-035 Single-shot read: base_adr = 22'h000100, len = 2, slave acks every cycle -> 8 words pushed from byte addresses 0x000400 to 0x00041C; cti sequence 2,2,2,7 per burst; done pulses once; busy = 0.
REQ-036 Backpressure: FIFO_AW = 4, len = 8, no pops -> fetching stalls in WAIT at level = 16 with wb_cyc low; 4 pops -> exactly one further burst is issued.
REQ-037 Pop while empty, and simultaneous push and pop at level = 5 -> empty pop is ignored; level stays 5.
REQ-038 Address wrap: base_adr = 22'h3FFFFC, len = 2 -> second burst starts at wb_adr = 0x000000.
REQ-039 Reset asserted on beat 2 of a burst -> wb_cyc = 0, level = 0 and empty = 1 asynchronously; no done pulse.
REQ-040 Loop mode (DMA_LOOP_EN defined): len = 1 with continuous pops -> wb_adr repeats the base address; done pulses every 4 pushed words.

Source files
------------

// File: rtl/vid_dma_fetch_if.sv
// =============================================================================
// vid_dma_fetch_if : Wishbone classic/burst read port of the video DMA fetcher
// Revision: 1.0
// =============================================================================
`default_nettype none

interface vid_dma_fetch_if;
  logic [23:0] wb_adr;
  logic [2:0]  wb_cti;
  logic        wb_stb;
  logic        wb_cyc;
  logic        wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat_i;
  logic        wb_ack;

  modport master (
    output wb_adr, wb_cti, wb_stb, wb_cyc, wb_we, wb_sel,
    input  wb_dat_i, wb_ack
  );

  modport slave (
    input  wb_adr, wb_cti, wb_stb, wb_cyc, wb_we, wb_sel,
    output wb_dat_i, wb_ack
  );
endinterface

`default_nettype wire

// File: rtl/vid_dma_fetch.sv
// =============================================================================
// vid_dma_fetch : 4-beat Wishbone burst reader feeding a show-ahead FIFO.
// Optional DMA_LOOP_EN: endless re-fetch of the same region.  Revision: 1.0
// =============================================================================
`default_nettype none

module vid_dma_fetch #(
  parameter int FIFO_AW = 4
) (
  input  logic                 wb_clk,
  input  logic                 wb_rst_n,
  vid_dma_fetch_if.master      wb,
  input  logic                 start,
  input  logic [21:0]          base_adr,
  input  logic [15:0]          len,
  input  logic                 rd_en,
  output logic [31:0]          rd_data,
  output logic                 empty,
  output logic [FIFO_AW:0]     level,
  output logic                 busy,
  output logic                 done
);

  localparam int                DEPTH   = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]  LVL_MAX = (FIFO_AW + 1)'(DEPTH - 4);
  localparam logic [FIFO_AW:0]  LVL_ONE = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW-1:0] PTR_ONE = {{(FIFO_AW-1){1'b0}}, 1'b1};
  localparam logic [2:0]        CTI_INC = 3'b010;
  localparam logic [2:0]        CTI_END = 3'b111;

  typedef enum logic [1:0] {IDLE, WAIT, BURST, FINISH} state_t;

  logic [1:0]         rst_sync_q, rst_sync_d;
  logic               rst_int_n;
  state_t             state_q, state_d;
  logic [21:0]        cur_adr_q, cur_adr_d;
  logic [15:0]        remaining_q, remaining_d;
  logic [1:0]         beat_q, beat_d;
  logic               cyc_q, cyc_d;
  logic [2:0]         cti_q, cti_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   level_q, level_d;
  logic [31:0]        mem_q [DEPTH];
  logic               push, pop;
  logic [21:0]        start_adr;
  logic [15:0]        start_cnt;
  logic               unused_adr_lsb;
`ifdef DMA_LOOP_EN
  logic [21:0]        base_q, base_d;
  logic [15:0]        cnt_q, cnt_d;
`endif

  // Assertion is immediate; release reaches the core only after two edges.
  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) rst_sync_q <= 2'b00;
    else           rst_sync_q <= rst_sync_d;
  end
  assign rst_int_n = rst_sync_q[1];

  assign start_adr      = {base_adr[21:2], 2'b00};
  assign start_cnt      = (len == 16'd0) ? 16'd1 : len;
  assign unused_adr_lsb = &{1'b0, base_adr[1:0]};

  assign push = (state_q == BURST) && wb.wb_ack;
  assign pop  = rd_en && (level_q != '0);

  always_comb begin
    state_d     = state_q;
    cur_adr_d   = cur_adr_q;
    remaining_d = remaining_q;
    beat_d      = beat_q;
    cyc_d       = cyc_q;
    cti_d       = cti_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    wr_ptr_d    = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    level_d     = level_q;
    if (push && !pop)      level_d = level_q + LVL_ONE;
    else if (pop && !push) level_d = level_q - LVL_ONE;
`ifdef DMA_LOOP_EN
    base_d = base_q;
    cnt_d  = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          cur_adr_d   = start_adr;
          remaining_d = start_cnt;
          wr_ptr_d    = '0;
          rd_ptr_d    = '0;
          level_d     = '0;
          busy_d      = 1'b1;
          state_d     = WAIT;
`ifdef DMA_LOOP_EN
          base_d = start_adr;
          cnt_d  = start_cnt;
`endif
        end
      end
      WAIT: begin
        // Room for a whole burst guarantees a full FIFO is never pushed.
        if (level_q <= LVL_MAX) begin
          cyc_d   = 1'b1;
          cti_d   = CTI_INC;
          beat_d  = 2'd0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (wb.wb_ack) begin
          cur_adr_d = cur_adr_q + 22'd1;
          beat_d    = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            cyc_d       = 1'b0;
            cti_d       = 3'b000;
            remaining_d = remaining_q - 16'd1;
            if (remaining_q == 16'd1) begin
              done_d  = 1'b1;
              state_d = FINISH;
            end else begin
              state_d = WAIT;
            end
          end else if (beat_q == 2'd2) begin
            cti_d = CTI_END;
          end
        end
      end
      FINISH: begin
`ifdef DMA_LOOP_EN
        cur_adr_d   = base_q;
        remaining_d = cnt_q;
        state_d     = WAIT;
`else
        busy_d  = 1'b0;
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q     <= IDLE;
      cur_adr_q   <= '0;
      remaining_q <= '0;
      beat_q      <= '0;
      cyc_q       <= 1'b0;
      cti_q       <= 3'b000;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
`ifdef DMA_LOOP_EN
      base_q      <= '0;
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cur_adr_q   <= cur_adr_d;
      remaining_q <= remaining_d;
      beat_q      <= beat_d;
      cyc_q       <= cyc_d;
      cti_q       <= cti_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
`ifdef DMA_LOOP_EN
      base_q      <= base_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

  always_ff @(posedge wb_clk) begin
    if (push) mem_q[wr_ptr_q] <= wb.wb_dat_i;
  end

  assign rd_data   = mem_q[rd_ptr_q];
  assign empty     = (level_q == '0);
  assign level     = level_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign wb.wb_adr = {cur_adr_q, 2'b00};
  assign wb.wb_cti = cti_q;
  assign wb.wb_cyc = cyc_q;
  assign wb.wb_stb = cyc_q;
  assign wb.wb_we  = 1'b0;
  assign wb.wb_sel = 4'hF;

endmodule

`default_nettype wire

// File: tb/tb_vid_dma_fetch.sv
// =============================================================================
// tb_vid_dma_fetch : scoreboard bench for vid_dma_fetch (bus beats and FIFO data)
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_vid_dma_fetch;
  localparam int FIFO_AW = 4;

  logic              wb_clk   = 1'b0;
  logic              wb_rst_n = 1'b0;
  logic              start    = 1'b0;
  logic [21:0]       base_adr = '0;
  logic [15:0]       len      = '0;
  logic              rd_en    = 1'b0;
  logic [31:0]       rd_data;
  logic              empty;
  logic [FIFO_AW:0]  level;
  logic              busy;
  logic              done;

  vid_dma_fetch_if bus ();

  vid_dma_fetch #(.FIFO_AW(FIFO_AW)) dut (
    .wb_clk   (wb_clk),
    .wb_rst_n (wb_rst_n),
    .wb       (bus),
    .start    (start),
    .base_adr (base_adr),
    .len      (len),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .empty    (empty),
    .level    (level),
    .busy     (busy),
    .done     (done)
  );

  always #5 wb_clk = ~wb_clk;

  int          n_checks   = 0;
  int          n_fail     = 0;
  int          done_cnt   = 0;
  int          beat_cnt   = 0;
  int          ack_budget = 0;
  logic [26:0] exp_bus [$];
  logic [31:0] exp_data [$];
  logic [26:0] e_bus;
  logic [31:0] e_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave: acks every cycle while the budget lasts, data tagged with its address.
  initial begin
    bus.wb_ack   = 1'b0;
    bus.wb_dat_i = '0;
    forever begin
      @(posedge wb_clk);
      #1;
      if (bus.wb_cyc && ack_budget > 0) begin
        bus.wb_ack   = 1'b1;
        bus.wb_dat_i = {8'hA5, bus.wb_adr};
        ack_budget--;
      end else begin
        bus.wb_ack   = 1'b0;
        bus.wb_dat_i = '0;
      end
    end
  end

  always @(negedge wb_clk) begin
    if (wb_rst_n && bus.wb_cyc && bus.wb_ack) begin
      beat_cnt++;
      if (exp_bus.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL bus_extra: got beat at adr 0x%06h, expected none", bus.wb_adr);
      end else begin
        e_bus = exp_bus.pop_front();
        check("wb_adr", 32'(bus.wb_adr), 32'(e_bus[26:3]));
        check("wb_cti", 32'(bus.wb_cti), 32'(e_bus[2:0]));
      end
      check("wb_stb_we_sel", 32'({bus.wb_stb, bus.wb_we, bus.wb_sel}), 32'(6'b10_1111));
    end
  end

  always @(negedge wb_clk) begin
    if (wb_rst_n && rd_en && !empty) begin
      if (exp_data.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL data_extra: got 0x%08h, expected none", rd_data);
      end else begin
        e_data = exp_data.pop_front();
        check("rd_data", rd_data, e_data);
      end
    end
  end

  always @(negedge wb_clk) begin
    if (done) done_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge wb_clk);
    #2;
  endtask

  task automatic expect_bursts(input logic [23:0] byte_base, input int n);
    logic [23:0] a;
    for (int b = 0; b < n; b++) begin
      for (int k = 0; k < 4; k++) begin
        a = byte_base + 24'(16 * b + 4 * k);
        exp_bus.push_back({a, (k == 3) ? 3'd7 : 3'd2});
        exp_data.push_back({8'hA5, a});
      end
    end
  endtask

  task automatic do_start(input logic [21:0] b, input logic [15:0] l);
    tick(1);
    base_adr = b;
    len      = l;
    start    = 1'b1;
    tick(1);
    start    = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max);
    int d0 = done_cnt;
    for (int i = 0; i < max && done_cnt == d0; i++) @(posedge wb_clk);
    #2;
    if (done_cnt == d0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got no done pulse, expected one within %0d cycles", name, max);
    end
  endtask

  task automatic wait_beats(input string name, input int target, input int max);
    for (int i = 0; i < max && beat_cnt < target; i++) @(posedge wb_clk);
    #2;
    check(name, 32'(beat_cnt >= target), 32'd1);
  endtask

  task automatic wait_level(input string name, input int v, input int max);
    for (int i = 0; i < max && 32'(level) != v; i++) tick(1);
    check(name, 32'(level), 32'(v));
  endtask

  task automatic drain(input string name, input int max);
    int i;
    rd_en = 1'b1;
    for (i = 0; i < max; i++) begin
      tick(1);
      if (exp_data.size() == 0 && empty && !busy) break;
    end
    rd_en = 1'b0;
    check(name, 32'(i < max), 32'd1);
  endtask

  initial begin
    int d0;
    int b0;

    tick(3);
    check("rst_cyc",   32'(bus.wb_cyc), 32'd0);
    check("rst_stb",   32'(bus.wb_stb), 32'd0);
    check("rst_busy",  32'(busy),       32'd0);
    check("rst_done",  32'(done),       32'd0);
    check("rst_cti",   32'(bus.wb_cti), 32'd0);
    check("rst_adr",   32'(bus.wb_adr), 32'd0);
    check("rst_level", 32'(level),      32'd0);
    check("rst_empty", 32'(empty),      32'd1);

    // A start on the first edge after release must fall inside the sync window.
    @(negedge wb_clk);
    wb_rst_n = 1'b1;
    base_adr = 22'h000100;
    len      = 16'd1;
    start    = 1'b1;
    @(posedge wb_clk);
    #2;
    start = 1'b0;
    tick(2);
    check("start_in_sync_window", 32'(busy), 32'd0);
    ack_budget = 1000000;

`ifdef DMA_LOOP_EN
    d0 = done_cnt;
    b0 = beat_cnt;
    ack_budget = 12;
    expect_bursts(24'h000040, 1);
    expect_bursts(24'h000040, 1);
    expect_bursts(24'h000040, 1);
    do_start(22'h000010, 16'd1);
    rd_en = 1'b1;
    wait_beats("loop_beats", b0 + 12, 200);
    tick(10);
    rd_en = 1'b0;
    check("loop_done_count", 32'(done_cnt - d0), 32'd3);
    check("loop_busy",       32'(busy),          32'd1);
`else
    // Single-shot read of two bursts.
    d0 = done_cnt;
    expect_bursts(24'h000400, 2);
    do_start(22'h000100, 16'd2);
    wait_done("single_done", 100);
    tick(2);
    check("single_done_once", 32'(done_cnt - d0), 32'd1);
    check("single_busy",      32'(busy),          32'd0);
    check("single_level",     32'(level),         32'd8);
    drain("single_drain", 100);
    check("single_empty", 32'(empty), 32'd1);

    // Backpressure: no pops until the FIFO is full.
    d0 = done_cnt;
    b0 = beat_cnt;
    expect_bursts(24'h000800, 8);
    do_start(22'h000200, 16'd8);
    tick(60);
    check("bp_level_full", 32'(level),         32'd16);
    check("bp_cyc_low",    32'(bus.wb_cyc),    32'd0);
    check("bp_busy",       32'(busy),          32'd1);
    check("bp_beats",      32'(beat_cnt - b0), 32'd16);
    rd_en = 1'b1;
    tick(4);
    rd_en = 1'b0;
    tick(30);
    check("bp_one_more_burst", 32'(beat_cnt - b0), 32'd20);
    check("bp_level_refull",   32'(level),         32'd16);
    check("bp_cyc_low2",       32'(bus.wb_cyc),    32'd0);
    drain("bp_drain", 400);
    check("bp_done_once", 32'(done_cnt - d0), 32'd1);

    // Pop while empty is ignored.
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    check("empty_pop_level", 32'(level), 32'd0);
    check("empty_pop_empty", 32'(empty), 32'd1);

    // Simultaneous push and pop at level 5.
    d0 = done_cnt;
    ack_budget = 5;
    expect_bursts(24'h000C00, 2);
    do_start(22'h000300, 16'd2);
    wait_level("pp_reach5", 5, 100);
    tick(3);
    check("pp_stalled_level", 32'(level),      32'd5);
    check("pp_stalled_cyc",   32'(bus.wb_cyc), 32'd1);
    ack_budget = 1;
    tick(1);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    check("pp_level_same", 32'(level), 32'd5);
    ack_budget = 1000000;
    drain("pp_drain", 200);
    check("pp_done_once", 32'(done_cnt - d0), 32'd1);

    // Address wrap at the top of the 16 MB space.
    d0 = done_cnt;
    expect_bursts(24'hFFFFF0, 2);
    do_start(22'h3FFFFC, 16'd2);
    drain("wrap_drain", 200);
    check("wrap_done_once", 32'(done_cnt - d0), 32'd1);

    // Reset while the burst waits on beat 2.
    b0 = beat_cnt;
    ack_budget = 2;
    exp_bus.push_back({24'h000100, 3'd2});
    exp_bus.push_back({24'h000104, 3'd2});
    do_start(22'h000040, 16'd2);
    wait_beats("rst_mid_beats", b0 + 2, 100);
    tick(2);
    check("rst_mid_cyc_before", 32'(bus.wb_cyc), 32'd1);
    check("rst_mid_cti_before", 32'(bus.wb_cti), 32'd2);
    check("rst_mid_level_before", 32'(level),    32'd2);
    d0 = done_cnt;
    #1;
    wb_rst_n = 1'b0;
    #1;
    check("rst_mid_cyc",   32'(bus.wb_cyc), 32'd0);
    check("rst_mid_level", 32'(level),      32'd0);
    check("rst_mid_empty", 32'(empty),      32'd1);
    check("rst_mid_busy",  32'(busy),       32'd0);
    exp_data.delete();
    tick(3);
    @(negedge wb_clk);
    wb_rst_n = 1'b1;
    tick(6);
    check("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
    check("rst_mid_idle",    32'(busy),          32'd0);
`endif

    check("exp_bus_left",  32'(exp_bus.size()),  32'd0);
    check("exp_data_left", 32'(exp_data.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule

`default_nettype wire
